mem_axil_master: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs. It converts one load or store per instruction into a single AXI4-Lite master transaction.
- Handles byte-lane steering on stores, and lane extraction plus sign/zero extension on loads.
- Holds the pipeline via mem_stall until the transaction completes.
- Sits between the EX/MEM register and the SoC AXI4-Lite interconnect; load data feeds the MEM/WB register.

---
 rtl/mem_axil_master.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_axil_master.sv
// mem_axil_master
//   Converts one MEM-stage load or store into a single AXI4-Lite master
//   transaction. Stores are byte-lane steered. Loads are lane-extracted and
//   then sign- or zero-extended. The pipeline is held through mem_stall until
//   the transaction finishes.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_memory_write/read         store / load request from EX/MEM (write wins)
//   mem_memory_load_type          000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, other LW
//   mem_memory_store_type         00 SB, 01 SH, 10 SW, 11 none
//   mem_result, mem_op2_selected  byte address, store data
//   mem_stall                     combinational pipeline hold
//   load_data / load_valid        extended load result and its one-cycle pulse
//   misaligned, bus_error         one-cycle status pulses
//   axi_*                         AXI4-Lite master channels (prot tied to 0)
module mem_axil_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_memory_write,
  input  logic                  mem_memory_read,
  input  logic [2:0]            mem_memory_load_type,
  input  logic [1:0]            mem_memory_store_type,
  input  logic [31:0]           mem_result,
  input  logic [31:0]           mem_op2_selected,
  output logic                  mem_stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [2:0]            axi_awprot,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Select the addressed lane, then extend it according to the load type.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ld_type);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Halfword loads are 001/101; every code other than the byte and halfword ones is a word.
  function automatic logic load_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
    logic m;
    case (ld_type)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = off[0];
      default:        m = (off != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic store_misaligned(input logic [1:0] st_type, input logic [1:0] off);
    logic m;
    case (st_type)
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            ld_type_q, ld_type_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_error_q, bus_error_d;
  logic [1:0]            req_off_s;

  assign req_off_s = mem_result[1:0];

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ld_type_d    = ld_type_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_memory_write) begin
          addr_d = mem_result[ADDR_WIDTH-1:0];
          case (mem_memory_store_type)
            2'b00: begin
              wdata_d = {4{mem_op2_selected[7:0]}};
              wstrb_d = 4'b0001 << req_off_s;
            end
            2'b01: begin
              wdata_d = {2{mem_op2_selected[15:0]}};
              wstrb_d = 4'b0011 << req_off_s;
            end
            default: begin
              wdata_d = mem_op2_selected;
              wstrb_d = 4'b1111;
            end
          endcase
          if (store_misaligned(mem_memory_store_type, req_off_s)) begin
            misaligned_d = 1'b1;
            state_d      = S_DONE;
          end else if (mem_memory_store_type == 2'b11) begin
            state_d = S_DONE;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end
        end else if (mem_memory_read) begin
          addr_d    = mem_result[ADDR_WIDTH-1:0];
          ld_type_d = mem_memory_load_type;
          if (load_misaligned(mem_memory_load_type, req_off_s)) begin
            misaligned_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        // Each valid drops only after its own handshake; wait for both.
        awvalid_d = awvalid_q & ~axi_awready;
        wvalid_d  = wvalid_q & ~axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid) begin
          bready_d    = 1'b0;
          bus_error_d = (axi_bresp != 2'b00);
          state_d     = S_DONE;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid) begin
          rready_d     = 1'b0;
          load_valid_d = 1'b1;
          bus_error_d  = (axi_rresp != 2'b00);
          load_data_d  = (axi_rresp != 2'b00) ? 32'd0
                                              : extend_load(axi_rdata, addr_q[1:0], ld_type_q);
          state_d      = S_DONE;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_DONE: begin
        // The pipeline advances on this edge; the still-held request is ignored.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ld_type_q    <= 3'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ld_type_q    <= ld_type_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // Stall covers the request cycle itself, so it depends on the live request inputs.
  assign mem_stall = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                     ((state_q == S_IDLE) && (mem_memory_read || mem_memory_write));

  assign axi_awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign axi_araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;

endmodule
